// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry registered between bits.
// Latency: operands accepted on edge E0, out_valid high after edge E0+WIDTH (WIDTH+1 cycles min, +1 to re-arm).
// Backpressure: result held in DONE until out_ready; in_ready stays low from acceptance until DONE exits.
//
// Ports: clk/rst_n (async active-low), in_valid/in_ready + a, b, c_in (operand side),
//        out_valid/out_ready + sum, c_out (result side), busy (high in RUN or DONE).
// Optional macro SERIAL_ADDER_SUB_EN adds input `sub`: when set at acceptance the block computes a - b
// (b inverted, carry forced to 1); c_out=1 then means no borrow.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q, sum_nxt;
    logic [WIDTH-1:0] b_load;
    logic            carry_q, cout_q, c_load;
    logic [CW-1:0]   cnt_q;
    logic            fa_s, fa_c;
    logic            accept, last_bit;

    full_adder u_fa (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : c_in;
`else
    assign b_load = b;
    assign c_load = c_in;
`endif

    assign accept   = in_valid && (state_q == S_IDLE);
    assign last_bit = (state_q == S_RUN) && (cnt_q == LAST);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign sum_nxt = WIDTH'({fa_s, sum_sr} >> 1);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // sum_sr is the working shifter; sum_q/cout_q are loaded only on the last bit so the
    // visible result stays frozen from DONE until the next DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= fa_c;
            sum_sr  <= sum_nxt;
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) begin
                sum_q  <= sum_nxt;
                cout_q <= fa_c;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = cout_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one instance of the existing `full_adder` cell.
- Stages operands LSB-first into the cell, registers the carry between bits, and assembles the result word.
- Sits directly upstream and downstream of `full_adder`: it drives x/y/c_in and consumes s/c_out.
- Valid/ready handshakes on both sides so it can drop into a datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand word available
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in for bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result word
- c_out  output  1  final carry-out
- busy  output  1  high while in RUN or DONE

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces IDLE.
  - Reset clears all registers: shift regs, carry reg, bit counter, sum, c_out = 0.
  - Output values in reset: in_ready=1, out_valid=0, busy=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready, latch a and b into shift regs, carry reg <= c_in, counter <= 0, go to RUN.
  - RUN: in_ready=0, out_valid=0, busy=1.
    - Each cycle: full_adder x = a_sr[0], y = b_sr[0], c_in = carry reg.
    - On the edge: s shifts into the MSB of sum_sr (right shift), carry reg <= c_out, a_sr/b_sr shift right, counter++.
    - When counter == WIDTH-1 on that edge, go to DONE.
  - DONE: out_valid=1; sum = sum_sr; c_out = carry reg; both held stable. On out_ready, go to IDLE.
- Latency:
  - Operands accepted on edge E0.
  - out_valid high after edge E0+WIDTH.
  - Minimum of WIDTH+1 cycles per operation, plus one for the return to IDLE.
- No overlap: in_ready is low from acceptance until the DONE->IDLE transition. in_valid is ignored outside IDLE.
- Back-to-back: IDLE accepts new operands on the first cycle after DONE exits. in_ready is never combinationally tied to out_ready.
- Arithmetic: {c_out, sum} = a + b + c_in, exact, no saturation.
- WIDTH=1: RUN lasts exactly one cycle; behaviour is then the full_adder truth table, registered.
- Held outputs: sum and c_out hold their last result after out_valid drops and until the next DONE. Only out_valid qualifies them.
- Reset mid-RUN or mid-DONE: partial result is discarded, no out_valid pulse, block returns to IDLE immediately.
- in_valid and out_ready never interact in the same state, so there is no simultaneous-event conflict.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port `sub` (1 bit), sampled on operand acceptance.
  - sub=1 latches ~b into b_sr and forces carry reg <= 1, ignoring c_in. Result is a - b.
  - In this mode c_out=1 means no borrow (a >= b unsigned).
  - sub=0 gives normal add.
- Undefined: no `sub` port; addition only; RTL is identical to the add path.

Test Plan:
- WIDTH=1, all 8 {a,b,c_in} combinations, out_ready=1 -> {c_out,sum} match the full-adder truth table; each out_valid arrives 1 cycle after acceptance.
- WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. out_valid rises exactly 8 cycles after the accept edge and busy=1 throughout.
- WIDTH=8, a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1. Then a=0x12, b=0x34, c_in=0 issued back-to-back -> sum=0x46, c_out=0, accepted on the first IDLE cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/c_out stable, in_ready=0. A pulse on in_valid during this window is not accepted.
- Reset mid-RUN: assert rst_n=0 on bit 3 of a=0x0F+0xF0 -> all outputs go to reset values immediately (async), no out_valid. After release, a fresh 0x01+0x01 gives 0x02.
- With SERIAL_ADDER_SUB_EN, sub=1: a=0x05, b=0x07 -> sum=0xFE, c_out=0; a=0x07, b=0x05 -> sum=0x02, c_out=1.
